// File: rtl/i2s_rx_fifo.sv
// sync_fifo: generic single-clock FIFO with a first-word-fall-through read port.
// Latency: a write is visible on rd_dat one cycle later; no write-to-read bypass.
// Backpressure: caller writes only when !full or reading in the same cycle; reads only when !empty.
module sync_fifo #(
    parameter int DW = 64,
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [DW-1:0] wr_dat,
    input  logic          rd_en,
    output logic [DW-1:0] rd_dat,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty
);
    localparam int DEPTH = 1 << AW;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   cnt;

    // Storage array: plain registers, contents need no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_dat;
        end
    end

    // Pointers wrap naturally at DEPTH; occupancy moves only on write-xor-read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_en, rd_en})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    assign rd_dat = mem[rd_ptr];
    assign count  = cnt;
    assign full   = (cnt == FULL_CNT);
    assign empty  = (cnt == '0);

endmodule

// i2s_rx_fifo: captures each completed stereo frame (lrclk fall) and queues {left,right}.
// Latency: capture strobe one cycle after the lrclk falling edge, frame on m_data one cycle after that.
// Backpressure: m_valid/m_ready stream; frames arriving while full are dropped and flagged in sticky overflow.
module i2s_rx_fifo #(
    parameter int AUDIO_DW   = 32,
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                  sclk,
    input  logic                  rst_n,
    input  logic                  lrclk,
    input  logic [AUDIO_DW-1:0]   left_chan,
    input  logic [AUDIO_DW-1:0]   right_chan,
    input  logic                  enable,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [2*AUDIO_DW-1:0] m_data,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  overflow,
    input  logic                  clr_overflow
);
    logic lrclk_r;
    logic nedge;
    logic cap;
    logic full;
    logic empty;
    logic push;
    logic pop;
    logic drop;
    logic ovf_q;

    // lrclk_r resets low so an lrclk already low at reset release never looks like a fall.
    assign nedge = lrclk_r & ~lrclk;

    // Edge detector and capture strobe; the receiver refreshes its samples on the nedge
    // clock edge, so the words are only stable one cycle later.
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            lrclk_r <= 1'b0;
            cap     <= 1'b0;
        end else begin
            lrclk_r <= lrclk;
            cap     <= nedge;
        end
    end

    // A full FIFO still accepts a frame when the head leaves in the same cycle.
    assign m_valid = ~empty;
    assign pop     = m_valid & m_ready;
    assign push    = cap & enable & (~full | pop);
    assign drop    = cap & enable & full & ~pop;

    // Sticky overflow; a drop wins over a clear landing in the same cycle.
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (drop) begin
            ovf_q <= 1'b1;
        end else if (clr_overflow) begin
            ovf_q <= 1'b0;
        end
    end

    assign overflow = ovf_q;

    sync_fifo #(
        .DW (2 * AUDIO_DW),
        .AW (DEPTH_LOG2)
    ) u_fifo (
        .clk    (sclk),
        .rst_n  (rst_n),
        .wr_en  (push),
        .wr_dat ({left_chan, right_chan}),
        .rd_en  (pop),
        .rd_dat (m_data),
        .count  (level),
        .full   (full),
        .empty  (empty)
    );

endmodule

// File: tb/tb_i2s_rx_fifo.sv
// Bench for i2s_rx_fifo: frame-level queue model checked every cycle plus directed scenarios.
module tb_i2s_rx_fifo;
    localparam int DEPTH = 8;

    logic        sclk = 1'b0;
    logic        rst_n;
    logic        lrclk;
    logic [31:0] left_chan;
    logic [31:0] right_chan;
    logic        enable;
    logic        m_valid;
    logic        m_ready;
    logic [63:0] m_data;
    logic [3:0]  level;
    logic        overflow;
    logic        clr_overflow;

    i2s_rx_fifo #(
        .AUDIO_DW   (32),
        .DEPTH_LOG2 (3)
    ) dut (
        .sclk         (sclk),
        .rst_n        (rst_n),
        .lrclk        (lrclk),
        .left_chan    (left_chan),
        .right_chan   (right_chan),
        .enable       (enable),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data),
        .level        (level),
        .overflow     (overflow),
        .clr_overflow (clr_overflow)
    );

    always #5 sclk = ~sclk;

    // Reference model: queue of stored frames plus sticky overflow flag.
    logic [63:0] q [$];
    bit          ovf_m;
    bit          fell;
    bit          lr_prev;
    int          rdy_mode;   // 0 low, 1 high, 2 random (mostly low), 3 high only on capture cycle
    int          clr_mode;   // 0 never, 1 always, 2 only on capture cycle
    logic [31:0] nxt_l;
    logic [31:0] nxt_r;
    int          n_cmp;
    int          n_mis;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One sclk cycle, entered and left at a falling edge.
    task automatic cyc(input bit lr);
        bit cap_now;
        bit pop;
        bit push;
        bit drop;
        logic [63:0] head;
        chk("cyc_valid", 64'(m_valid), 64'(q.size() != 0));
        chk("cyc_level", 64'(level), 64'(q.size()));
        chk("cyc_ovf", 64'(overflow), 64'(ovf_m));
        if (q.size() != 0) begin
            chk("cyc_data", m_data, q[0]);
        end
        // The frame fell at the previous falling edge, so the receiver's fresh words
        // appear now and get written at the coming rising edge.
        cap_now = fell;
        lrclk   = lr;
        fell    = lr_prev & !lr;
        lr_prev = lr;
        if (cap_now) begin
            left_chan  = nxt_l;
            right_chan = nxt_r;
        end
        case (rdy_mode)
            0:       m_ready = 1'b0;
            1:       m_ready = 1'b1;
            2:       m_ready = ($urandom_range(0, 3) == 0);
            default: m_ready = cap_now;
        endcase
        clr_overflow = (clr_mode == 1) || (clr_mode == 2 && cap_now);
        pop  = (q.size() != 0) && m_ready;
        push = cap_now && enable && (q.size() < DEPTH || pop);
        drop = cap_now && enable && !push;
        if (pop) begin
            head = q.pop_front();
        end
        if (push) begin
            q.push_back({nxt_l, nxt_r});
        end
        if (drop) begin
            ovf_m = 1'b1;
        end else if (clr_overflow) begin
            ovf_m = 1'b0;
        end
        @(negedge sclk);
    endtask

    task automatic send_frame(input logic [31:0] l, input logic [31:0] r);
        nxt_l = l;
        nxt_r = r;
        repeat (3) cyc(1'b1);
        repeat (3) cyc(1'b0);
    endtask

    initial begin
        logic [31:0] nn;
        n_cmp = 0;
        n_mis = 0;
        rst_n = 1'b0;
        lrclk = 1'b0;
        enable = 1'b1;
        m_ready = 1'b0;
        clr_overflow = 1'b0;
        left_chan = '0;
        right_chan = '0;
        rdy_mode = 0;
        clr_mode = 0;
        ovf_m = 1'b0;
        fell = 1'b0;
        lr_prev = 1'b0;
        nxt_l = '0;
        nxt_r = '0;

        #12;
        chk("rst_level", 64'(level), 64'd0);
        chk("rst_valid", 64'(m_valid), 64'd0);
        chk("rst_ovf", 64'(overflow), 64'd0);
        @(negedge sclk);
        rst_n = 1'b1;

        // Reset released with lrclk low: nothing captured.
        repeat (6) cyc(1'b0);
        chk("t1_level", 64'(level), 64'd0);
        chk("t1_valid", 64'(m_valid), 64'd0);

        // Single known frame, then one ready pulse.
        send_frame(32'h1234_5678, 32'h9ABC_DEF0);
        chk("t2_valid", 64'(m_valid), 64'd1);
        chk("t2_data", m_data, 64'h1234_5678_9ABC_DEF0);
        rdy_mode = 1;
        cyc(1'b1);
        rdy_mode = 0;
        chk("t2_level", 64'(level), 64'd0);

        // Nine frames into an eight-deep FIFO with no consumer.
        for (int n = 1; n <= 9; n++) begin
            nn = 32'(n);
            send_frame(nn, ~nn);
        end
        chk("t3_level", 64'(level), 64'd8);
        chk("t3_ovf", 64'(overflow), 64'd1);
        rdy_mode = 1;
        for (int n = 1; n <= 8; n++) begin
            nn = 32'(n);
            chk("t3_order", m_data, {nn, ~nn});
            cyc(1'b1);
        end
        chk("t3_empty", 64'(m_valid), 64'd0);
        rdy_mode = 0;

        // Full with a pop on the capture cycle, then a drop racing clr_overflow.
        clr_mode = 1;
        cyc(1'b1);
        clr_mode = 0;
        chk("t4_clr", 64'(overflow), 64'd0);
        for (int n = 0; n < 8; n++) begin
            send_frame($urandom, $urandom);
        end
        chk("t4_full", 64'(level), 64'd8);
        rdy_mode = 3;
        send_frame(32'hA5A5_0001, 32'h5A5A_0001);
        rdy_mode = 0;
        chk("t4_pushpop_level", 64'(level), 64'd8);
        chk("t4_pushpop_ovf", 64'(overflow), 64'd0);
        clr_mode = 2;
        send_frame(32'hDEAD_0002, 32'hBEEF_0002);
        clr_mode = 0;
        chk("t4_set_wins", 64'(overflow), 64'd1);
        rdy_mode = 1;
        repeat (10) cyc(1'b1);
        rdy_mode = 0;
        clr_mode = 1;
        cyc(1'b1);
        clr_mode = 0;

        // Disabled capture drops frames silently while stored frames still drain.
        send_frame(32'h0000_1111, 32'h0000_2222);
        send_frame(32'h0000_3333, 32'h0000_4444);
        enable = 1'b0;
        for (int n = 0; n < 3; n++) begin
            send_frame($urandom, $urandom);
        end
        chk("t5_level", 64'(level), 64'd2);
        chk("t5_ovf", 64'(overflow), 64'd0);
        rdy_mode = 1;
        repeat (3) cyc(1'b1);
        rdy_mode = 0;
        chk("t5_drained", 64'(level), 64'd0);
        enable = 1'b1;
        send_frame(32'hCAFE_F00D, 32'h0BAD_BEEF);
        chk("t5_reenable_level", 64'(level), 64'd1);
        chk("t5_reenable_data", m_data, 64'hCAFE_F00D_0BAD_BEEF);
        rdy_mode = 1;
        cyc(1'b1);
        rdy_mode = 0;

        // Asynchronous reset mid-stream, then random traffic across pointer wrap.
        for (int n = 0; n < 5; n++) begin
            send_frame($urandom, $urandom);
        end
        chk("t6_pre_level", 64'(level), 64'd5);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_level", 64'(level), 64'd0);
        chk("t6_async_valid", 64'(m_valid), 64'd0);
        q.delete();
        ovf_m = 1'b0;
        fell = 1'b0;
        lr_prev = 1'b0;
        @(negedge sclk);
        rst_n = 1'b1;
        send_frame(32'h0F0F_1234, 32'hF0F0_5678);
        chk("t6_first_data", m_data, 64'h0F0F_1234_F0F0_5678);
        chk("t6_first_level", 64'(level), 64'd1);
        rdy_mode = 2;
        for (int n = 0; n < 20; n++) begin
            send_frame($urandom, $urandom);
        end
        rdy_mode = 1;
        repeat (12) cyc(1'b1);
        chk("t6_final_level", 64'(level), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
